pad_data_monitor: RTL and testbench
===================================

PAD_DATA_MONITOR -- requirements
Module: pad_data_monitor

Interface
REQ-001 SHALL have parameter BCID_MAX, default 3564, the number of legal BCIDs per orbit (legal range 0..BCID_MAX-1).
REQ-002 SHALL have parameter CNT_W, default 16, the width of every error/break counter.
REQ-003 SHALL have port clk160  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  the asynchronous, active-low reset.
REQ-005 SHALL have port pad_data_in  input  116  the pad frame: [115:104] BCID, [103:0] channel hits.
REQ-006 SHALL have port pad_data_valid  input  1  qualifies pad_data_in; asserted only for frames with at least one hit.
REQ-007 SHALL have port linked  input  1  the upstream link-lock status.
REQ-008 SHALL have port clear_cnt  input  1  the clear request, acted on at its rising edge only.
REQ-009 SHALL have port mon_state  output  2  the current FSM state.
REQ-010 SHALL have port link_break_cnt  output  CNT_W  the number of linked 1->0 transitions.
REQ-011 SHALL have port bcid_err_cnt  output  CNT_W  the number of BCID errors.
REQ-012 SHALL have port hit_frame_cnt  output  32  the number of accepted valid frames.
REQ-013 SHALL have port last_bcid  output  12  the BCID of the most recent valid frame.
REQ-014 SHALL have port hit_mult  output  7  the hit count (popcount of [103:0]) of the last valid frame.
REQ-015 SHALL have port hit_mult_max  output  7  the largest hit_mult seen since the last clear.

Function
REQ-016 SHALL implement FSM states IDLE=0, SEED=1, TRACK=2; state 3 is unreachable and SHALL recover to IDLE.
REQ-017 SHALL move IDLE->SEED when linked=1.
REQ-018 SHALL, in SEED, on a valid frame, load last_bcid and move to TRACK, without a BCID check.
REQ-019 SHALL, in TRACK, flag a BCID error on a valid frame whose BCID is >=BCID_MAX or equals last_bcid.
REQ-020 SHALL, in TRACK, update last_bcid on every valid frame, including errored ones.
REQ-021 SHALL move any state->IDLE when linked=0; that transition takes priority over frame processing in the same cycle.
REQ-022 SHALL detect link break as linked registered 1 then 0, and increment link_break_cnt by exactly 1 per falling edge.
REQ-023 SHALL increment hit_frame_cnt on every valid frame while in SEED or TRACK; valid frames in IDLE are ignored.
REQ-024 SHALL give every counter and last_bcid a latency of 1 cycle from the input edge.
REQ-025 SHALL give hit_mult and hit_mult_max a latency of 2 cycles, and SHALL update them only on valid frames.
REQ-026 SHALL make all counters saturate at all-ones, with no wrap.
REQ-027 SHALL, on a clear_cnt rising edge, zero link_break_cnt, bcid_err_cnt, hit_frame_cnt and hit_mult_max one cycle later; FSM state and last_bcid are unaffected.
REQ-028 SHALL give clear priority over an increment landing in the same cycle; that event is lost.
REQ-029 SHALL treat a held-high clear_cnt as a single clear.

Reset
REQ-030 SHALL force, on reset_n=0, mon_state=IDLE and all outputs to 0, asynchronously.
REQ-031 SHALL reset the internal linked and clear_cnt edge registers to 0, so that a link already high at reset release counts no break.
REQ-032 SHALL discard any popcount pipeline contents when reset is asserted mid-frame.

Configuration
REQ-033 SHALL compile the hit-multiplicity path (popcount pipeline, hit_mult, hit_mult_max) only when macro PAD_MON_POPCOUNT_EN is defined.
REQ-034 SHALL, without PAD_MON_POPCOUNT_EN, tie hit_mult and hit_mult_max to 0 with no popcount logic instantiated; all other behaviour is identical.

Structure
REQ-035 SHALL place in shared package pad_mon_pkg: the FSM state encoding, the field constants BCID_MSB=115, BCID_LSB=104, HIT_W=104, and the default BCID_MAX.
REQ-036 SHALL implement the popcount as sub-module pad_popcount104: a 2-stage pipeline (13x8-bit partial sums, then a final sum) with a valid pass-through.

Verification
REQ-037 SHALL verify: reset release with linked=1, then valid frames with BCID 10, 11, 12 -> mon_state=TRACK, hit_frame_cnt=3, bcid_err_cnt=0, last_bcid=12.
REQ-038 SHALL verify: in TRACK, BCID 20 then BCID 20, then BCID 3564 -> bcid_err_cnt=2, last_bcid=3564 (0xDEC).
REQ-039 SHALL verify: linked toggled 1->0->1 three times -> link_break_cnt=3, mon_state passes IDLE->SEED each time, and the first frame after relock gives no BCID error.
REQ-040 SHALL verify: frame with hits [103:0]=all ones, then a frame with a single hit -> hit_mult=104 then 1 (2-cycle latency), hit_mult_max=104; with the macro undefined, both read 0.
REQ-041 SHALL verify: clear_cnt rising edge coincident with a valid frame, clear held 10 cycles -> all counters 0 one cycle later and remain 0; the next frame gives hit_frame_cnt=1.
REQ-042 SHALL verify: link_break_cnt forced near 0xFFFF (CNT_W=16), then 3 breaks -> counter holds 0xFFFF.

Source files
------------

// File: rtl/pad_mon_pkg.sv
// Shared definitions for the pad data monitor: FSM encoding, pad frame field layout,
// and a byte popcount helper used by the hit-multiplicity pipeline.
package pad_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_TRACK = 2'd2
    } mon_state_t;

    localparam int BCID_MSB         = 115;
    localparam int BCID_LSB         = 104;
    localparam int BCID_W           = BCID_MSB - BCID_LSB + 1;
    localparam int HIT_W            = 104;
    localparam int FRAME_W          = BCID_MSB + 1;
    localparam int BCID_MAX_DEFAULT = 3564;
    localparam int MULT_W           = 7;
    localparam int NUM_BYTES        = HIT_W / 8;

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, b[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pad_popcount104.sv
// Two-stage popcount of the 104 hit bits: registered 8-bit partial sums, then a
// registered final sum, with the input valid carried alongside.
module pad_popcount104
    import pad_mon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HIT_W-1:0]  data,
    input  logic              valid_in,
    output logic [MULT_W-1:0] count,
    output logic              valid_out
);

    logic [NUM_BYTES-1:0][3:0] part_next;
    logic [NUM_BYTES-1:0][3:0] part_reg;
    logic                      valid_s1_reg;
    logic [MULT_W-1:0]         sum_next;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            assign part_next[gi] = popcount8(data[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            sum_next = sum_next + MULT_W'(part_reg[i]);
        end
    end

    // Async reset flushes both stages so a frame caught mid-flight never emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_reg     <= '0;
            valid_s1_reg <= 1'b0;
            count        <= '0;
            valid_out    <= 1'b0;
        end else begin
            part_reg     <= part_next;
            valid_s1_reg <= valid_in;
            count        <= sum_next;
            valid_out    <= valid_s1_reg;
        end
    end

endmodule

// File: rtl/pad_data_monitor.sv
// Pad frame monitor: link/BCID tracking FSM with saturating error counters.
// Hit multiplicity (hit_mult, hit_mult_max) exists only when PAD_MON_POPCOUNT_EN is defined.
module pad_data_monitor
    import pad_mon_pkg::*;
#(
    parameter int unsigned BCID_MAX = BCID_MAX_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic               clk160,
    input  logic               reset_n,
    input  logic [FRAME_W-1:0] pad_data_in,
    input  logic               pad_data_valid,
    input  logic               linked,
    input  logic               clear_cnt,
    output logic [1:0]         mon_state,
    output logic [CNT_W-1:0]   link_break_cnt,
    output logic [CNT_W-1:0]   bcid_err_cnt,
    output logic [31:0]        hit_frame_cnt,
    output logic [BCID_W-1:0]  last_bcid,
    output logic [MULT_W-1:0]  hit_mult,
    output logic [MULT_W-1:0]  hit_mult_max
);

    mon_state_t        state_reg, state_next;
    logic              linked_d_reg;
    logic              clear_d_reg;
    logic [CNT_W-1:0]  link_break_cnt_reg, link_break_cnt_next;
    logic [CNT_W-1:0]  bcid_err_cnt_reg, bcid_err_cnt_next;
    logic [31:0]       hit_frame_cnt_reg, hit_frame_cnt_next;
    logic [BCID_W-1:0] last_bcid_reg, last_bcid_next;

    logic [BCID_W-1:0] frame_bcid;
    logic              tracking;
    logic              accept;
    logic              bcid_err;
    logic              link_break;
    logic              clear_pulse;

    assign frame_bcid  = pad_data_in[BCID_MSB:BCID_LSB];
    assign tracking    = (state_reg == ST_SEED) || (state_reg == ST_TRACK);
    // Loss of link wins over a frame arriving in the same cycle.
    assign accept      = pad_data_valid && linked && tracking;
    assign bcid_err    = accept && (state_reg == ST_TRACK) &&
                         ((32'(frame_bcid) >= BCID_MAX) || (frame_bcid == last_bcid_reg));
    assign link_break  = linked_d_reg && !linked;
    assign clear_pulse = clear_cnt && !clear_d_reg;

    always_comb begin
        state_next = state_reg;
        if (!linked) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_SEED;
                ST_SEED:  if (pad_data_valid) state_next = ST_TRACK;
                ST_TRACK: state_next = ST_TRACK;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        link_break_cnt_next = link_break_cnt_reg;
        bcid_err_cnt_next   = bcid_err_cnt_reg;
        hit_frame_cnt_next  = hit_frame_cnt_reg;
        last_bcid_next      = last_bcid_reg;
        if (accept) begin
            last_bcid_next = frame_bcid;
        end
        // A clear swallows any increment that lands with it.
        if (clear_pulse) begin
            link_break_cnt_next = '0;
            bcid_err_cnt_next   = '0;
            hit_frame_cnt_next  = '0;
        end else begin
            if (link_break && (link_break_cnt_reg != '1))
                link_break_cnt_next = link_break_cnt_reg + CNT_W'(1);
            if (bcid_err && (bcid_err_cnt_reg != '1))
                bcid_err_cnt_next = bcid_err_cnt_reg + CNT_W'(1);
            if (accept && (hit_frame_cnt_reg != '1))
                hit_frame_cnt_next = hit_frame_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            linked_d_reg       <= 1'b0;
            clear_d_reg        <= 1'b0;
            link_break_cnt_reg <= '0;
            bcid_err_cnt_reg   <= '0;
            hit_frame_cnt_reg  <= '0;
            last_bcid_reg      <= '0;
        end else begin
            state_reg          <= state_next;
            linked_d_reg       <= linked;
            clear_d_reg        <= clear_cnt;
            link_break_cnt_reg <= link_break_cnt_next;
            bcid_err_cnt_reg   <= bcid_err_cnt_next;
            hit_frame_cnt_reg  <= hit_frame_cnt_next;
            last_bcid_reg      <= last_bcid_next;
        end
    end

    assign mon_state      = state_reg;
    assign link_break_cnt = link_break_cnt_reg;
    assign bcid_err_cnt   = bcid_err_cnt_reg;
    assign hit_frame_cnt  = hit_frame_cnt_reg;
    assign last_bcid      = last_bcid_reg;

`ifdef PAD_MON_POPCOUNT_EN
    logic [MULT_W-1:0] mult_count;
    logic              mult_valid;
    logic [MULT_W-1:0] mult_hold_reg;
    logic [MULT_W-1:0] mult_max_reg;

    pad_popcount104 u_popcount (
        .clk       (clk160),
        .rst_n     (reset_n),
        .data      (pad_data_in[HIT_W-1:0]),
        .valid_in  (pad_data_valid),
        .count     (mult_count),
        .valid_out (mult_valid)
    );

    // Present the fresh count in its valid cycle, then hold it until the next frame.
    assign hit_mult     = mult_valid ? mult_count : mult_hold_reg;
    assign hit_mult_max = (mult_valid && (mult_count > mult_max_reg)) ? mult_count : mult_max_reg;

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            mult_hold_reg <= '0;
            mult_max_reg  <= '0;
        end else begin
            if (mult_valid)
                mult_hold_reg <= mult_count;
            if (clear_pulse)
                mult_max_reg <= '0;
            else
                mult_max_reg <= hit_mult_max;
        end
    end
`else
    logic unused_hits;
    assign unused_hits  = ^pad_data_in[HIT_W-1:0];
    assign hit_mult     = '0;
    assign hit_mult_max = '0;
`endif

endmodule

// File: tb/tb_pad_data_monitor.sv
// Scoreboard bench for pad_data_monitor: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pad_data_monitor;
    import pad_mon_pkg::*;

    localparam int F_STATE = 0, F_BRK = 1, F_ERR = 2, F_FRAMES = 3,
                   F_BCID = 4, F_MULT = 5, F_MAX = 6;

    logic               clk160 = 1'b0;
    logic               reset_n;
    logic [FRAME_W-1:0] pad_data_in;
    logic               pad_data_valid;
    logic               linked;
    logic               clear_cnt;
    logic [1:0]         mon_state;
    logic [15:0]        link_break_cnt;
    logic [15:0]        bcid_err_cnt;
    logic [31:0]        hit_frame_cnt;
    logic [11:0]        last_bcid;
    logic [6:0]         hit_mult;
    logic [6:0]         hit_mult_max;

    always #5 clk160 = ~clk160;

    pad_data_monitor dut (
        .clk160         (clk160),
        .reset_n        (reset_n),
        .pad_data_in    (pad_data_in),
        .pad_data_valid (pad_data_valid),
        .linked         (linked),
        .clear_cnt      (clear_cnt),
        .mon_state      (mon_state),
        .link_break_cnt (link_break_cnt),
        .bcid_err_cnt   (bcid_err_cnt),
        .hit_frame_cnt  (hit_frame_cnt),
        .last_bcid      (last_bcid),
        .hit_mult       (hit_mult),
        .hit_mult_max   (hit_mult_max)
    );

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk160) cyc <= cyc + 1;

    function automatic logic [31:0] mexp(input int v);
`ifdef PAD_MON_POPCOUNT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic void expect_at(input int dly, input int field,
                                      input logic [31:0] exp, input string name);
        chk_t c;
        int   idx;
        c.cyc = cyc + dly; c.field = field; c.exp = exp; c.name = name;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, c);
    endfunction

    function automatic logic [31:0] observe(input int field);
        case (field)
            F_STATE:  return 32'(mon_state);
            F_BRK:    return 32'(link_break_cnt);
            F_ERR:    return 32'(bcid_err_cnt);
            F_FRAMES: return hit_frame_cnt;
            F_BCID:   return 32'(last_bcid);
            F_MULT:   return 32'(hit_mult);
            default:  return 32'(hit_mult_max);
        endcase
    endfunction

    always @(negedge clk160) begin
        chk_t c;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            c = sb.pop_front();
            checks++;
            if (c.cyc < cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", c.name, c.cyc, cyc);
            end else if (observe(c.field) !== c.exp) begin
                errors++;
                $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", c.name, cyc, observe(c.field), c.exp);
            end else begin
                $display("ok   %s: cycle %0d value 0x%0h", c.name, cyc, c.exp);
            end
        end
    end

    task automatic next();
        @(posedge clk160);
        #1;
    endtask

    task automatic drive_frame(input logic [11:0] bcid, input logic [HIT_W-1:0] hits);
        pad_data_in    = {bcid, hits};
        pad_data_valid = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; linked = 1'b1; pad_data_valid = 1'b0;
        pad_data_in = '0; clear_cnt = 1'b0;
        next(); next();

        expect_at(1, F_STATE, 0, "rst_state");
        expect_at(1, F_BRK, 0, "rst_brk");
        expect_at(1, F_ERR, 0, "rst_err");
        expect_at(1, F_FRAMES, 0, "rst_frames");
        expect_at(1, F_BCID, 0, "rst_bcid");
        expect_at(1, F_MULT, 0, "rst_mult");
        expect_at(1, F_MAX, 0, "rst_max");
        next();

        // Link already high at release: straight to SEED, no break counted.
        reset_n = 1'b1;
        expect_at(1, F_STATE, 1, "seed_after_release");
        next();
        expect_at(1, F_BRK, 0, "no_break_at_release");

        drive_frame(12'd10, 104'h7);
        expect_at(1, F_STATE, 2, "track_after_seed");
        expect_at(1, F_FRAMES, 1, "frames_1");
        expect_at(1, F_BCID, 10, "bcid_10");
        expect_at(2, F_MULT, mexp(3), "mult_3");
        next();
        drive_frame(12'd11, 104'h1);
        expect_at(1, F_FRAMES, 2, "frames_2");
        expect_at(1, F_BCID, 11, "bcid_11");
        expect_at(2, F_MULT, mexp(1), "mult_1a");
        expect_at(2, F_MAX, mexp(3), "max_3");
        next();
        drive_frame(12'd12, 104'h1);
        expect_at(1, F_FRAMES, 3, "frames_3");
        expect_at(1, F_ERR, 0, "err_0_seq");
        expect_at(1, F_BCID, 12, "bcid_12");
        expect_at(1, F_STATE, 2, "state_track");
        next();
        pad_data_valid = 1'b0;
        next();

        drive_frame(12'd20, 104'h1);
        expect_at(1, F_ERR, 0, "err_0_bcid20");
        expect_at(1, F_BCID, 20, "bcid_20");
        next();
        drive_frame(12'd20, 104'h1);
        expect_at(1, F_ERR, 1, "err_dup");
        next();
        drive_frame(12'hDEC, 104'h1);
        expect_at(1, F_ERR, 2, "err_range");
        expect_at(1, F_BCID, 32'hDEC, "bcid_dec");
        expect_at(1, F_FRAMES, 6, "frames_6");
        next();
        pad_data_valid = 1'b0;
        next();

        drive_frame(12'd100, {HIT_W{1'b1}});
        expect_at(2, F_MULT, mexp(104), "mult_104");
        next();
        drive_frame(12'd101, 104'd1 << 57);
        expect_at(2, F_MULT, mexp(1), "mult_1b");
        expect_at(2, F_MAX, mexp(104), "max_104");
        expect_at(1, F_FRAMES, 8, "frames_8");
        expect_at(1, F_ERR, 2, "err_still_2");
        next();
        pad_data_valid = 1'b0;
        expect_at(2, F_MULT, mexp(1), "mult_hold");
        next(); next(); next();

        // Link drop coincident with a frame: frame discarded.
        linked = 1'b0;
        drive_frame(12'd500, 104'h1);
        expect_at(1, F_BRK, 1, "brk_1");
        expect_at(1, F_STATE, 0, "idle_1");
        expect_at(1, F_FRAMES, 8, "frames_drop_ignored");
        expect_at(1, F_BCID, 101, "bcid_drop_ignored");
        next();
        pad_data_valid = 1'b0;
        linked = 1'b1;
        expect_at(1, F_STATE, 1, "seed_1");
        next();
        linked = 1'b0;
        expect_at(1, F_BRK, 2, "brk_2");
        expect_at(1, F_STATE, 0, "idle_2");
        next();
        linked = 1'b1;
        expect_at(1, F_STATE, 1, "seed_2");
        next();
        linked = 1'b0;
        expect_at(1, F_BRK, 3, "brk_3");
        expect_at(1, F_STATE, 0, "idle_3");
        next();
        linked = 1'b1;
        expect_at(1, F_STATE, 1, "seed_3");
        next();
        // Same BCID as last_bcid, but SEED performs no check.
        drive_frame(12'd101, 104'h3);
        expect_at(1, F_STATE, 2, "track_relock");
        expect_at(1, F_ERR, 2, "no_err_relock");
        expect_at(1, F_FRAMES, 9, "frames_9");
        expect_at(2, F_MULT, mexp(2), "mult_2");
        next();
        pad_data_valid = 1'b0;
        next(); next(); next(); next();

        clear_cnt = 1'b1;
        drive_frame(12'd102, 104'h1);
        expect_at(1, F_FRAMES, 0, "clr_frames");
        expect_at(1, F_ERR, 0, "clr_err");
        expect_at(1, F_BRK, 0, "clr_brk");
        expect_at(1, F_MAX, 0, "clr_max");
        expect_at(1, F_BCID, 102, "clr_keeps_bcid");
        expect_at(1, F_STATE, 2, "clr_keeps_state");
        next();
        pad_data_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                expect_at(1, F_FRAMES, 0, "clr_hold_frames");
                expect_at(1, F_ERR, 0, "clr_hold_err");
                expect_at(1, F_BRK, 0, "clr_hold_brk");
            end
            next();
        end
        clear_cnt = 1'b0;
        drive_frame(12'd103, 104'h1);
        expect_at(1, F_FRAMES, 1, "frames_after_clr");
        expect_at(1, F_ERR, 0, "err_after_clr");
        next();
        pad_data_valid = 1'b0;
        next();

        force dut.link_break_cnt_reg = 16'hFFFD;
        next();
        release dut.link_break_cnt_reg;
        linked = 1'b0;
        expect_at(1, F_BRK, 32'hFFFE, "brk_fffe");
        next();
        linked = 1'b1;
        next();
        linked = 1'b0;
        expect_at(1, F_BRK, 32'hFFFF, "brk_ffff");
        next();
        linked = 1'b1;
        next();
        linked = 1'b0;
        expect_at(1, F_BRK, 32'hFFFF, "brk_saturated");
        next();
        linked = 1'b1;
        next(); next();

        // Reset asserted with a frame inside the popcount pipeline.
        drive_frame(12'd200, {HIT_W{1'b1}});
        next();
        pad_data_valid = 1'b0;
        reset_n = 1'b0;
        expect_at(0, F_MULT, 0, "async_rst_mult");
        expect_at(0, F_FRAMES, 0, "async_rst_frames");
        expect_at(0, F_STATE, 0, "async_rst_state");
        next();
        reset_n = 1'b1;
        expect_at(2, F_MULT, 0, "mult_flushed");
        expect_at(2, F_MAX, 0, "max_flushed");
        next();

        for (int i = 0; i < 20 && sb.size() > 0; i++) next();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d checks never reached", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
